tx_upconverter: RTL and testbench

Transmit-side counterpart of the 1-bit receive mixer. It takes baseband I/Q samples and the shared NCO sin/cos outputs and forms the quadrature product I·cos − Q·sin. The result is scaled by a keying envelope and converted to a 1-bit RF drive by a first-order sigma-delta modulator. An internal keying FSM ramps the envelope up and down on the key input to limit key clicks.

---
 rtl/tx_upconverter_if.sv | 16 +
 rtl/tx_upconverter.sv | 122 ++++++++++++
 tb/tb_tx_upconverter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/tx_upconverter_if.sv
// Baseband/NCO sample inputs, keying request and RF/status outputs of the transmit upconverter.
interface tx_upconverter_if;
  logic              key;
  logic signed [9:0] I_in;
  logic signed [9:0] Q_in;
  logic signed [9:0] sin_in;
  logic signed [9:0] cos_in;
  logic              RFOut;
  logic              tx_active;
  logic              ramp_done;

  modport master (output key, I_in, Q_in, sin_in, cos_in,
                  input  RFOut, tx_active, ramp_done);
  modport slave  (input  key, I_in, Q_in, sin_in, cos_in,
                  output RFOut, tx_active, ramp_done);
endinterface

// File: rtl/tx_upconverter.sv
// Quadrature upconverter (I*cos - Q*sin), keyed envelope ramp, first-order 1-bit sigma-delta RF drive.
module tx_upconverter #(
  parameter int RAMP_DIV  = 4,
  parameter int GAIN_BITS = 9
) (
  input logic             clk,
  input logic             rst_n,
  tx_upconverter_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;
  localparam logic [1:0] S_DOWN = 2'd3;
  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int PW = 22 + GAIN_BITS;
  localparam logic [GAIN_BITS-1:0] G_MAX = GAIN_BITS'(256);
  localparam logic [GAIN_BITS-1:0] G_ONE = GAIN_BITS'(1);
  localparam logic signed [22:0]   FS    = 23'sd524288;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [GAIN_BITS-1:0] gain_q, gain_d;
  logic                 tx_active_q, ramp_done_q;
  logic                 wrap;

  assign wrap = (cnt_q == CW'(RAMP_DIV - 1));

  // Ramp-end takes priority over a key change in the same cycle; the key is re-evaluated next state.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        gain_d = '0;
        if (bus.key) state_d = S_UP;
      end
      S_UP: begin
        if (wrap && gain_q >= G_MAX - G_ONE) begin
          gain_d  = G_MAX;
          state_d = S_ON;
        end else if (!bus.key) begin
          state_d = S_DOWN;
        end else if (wrap) begin
          gain_d = gain_q + G_ONE;
        end
      end
      S_ON: begin
        cnt_d  = '0;
        gain_d = G_MAX;
        if (!bus.key) state_d = S_DOWN;
      end
      default: begin
        if (gain_q == '0 || (wrap && gain_q == G_ONE)) begin
          gain_d  = '0;
          state_d = S_IDLE;
        end else if (bus.key) begin
          state_d = S_UP;
        end else if (wrap) begin
          gain_d = gain_q - G_ONE;
        end
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      gain_q      <= '0;
      tx_active_q <= 1'b0;
      ramp_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gain_q      <= gain_d;
      tx_active_q <= (state_d != S_IDLE);
      ramp_done_q <= (state_d == S_ON);
    end
  end

  logic signed [19:0] pi_q, pq_q;
  logic signed [20:0] sum_q, x_q, x_d;
  logic signed [PW-1:0] scaled;
  logic signed [22:0] acc_q, acc_d, x_ext;
  logic               rf_q;

  assign scaled = sum_q * $signed({1'b0, gain_q});
  assign x_d    = 21'(scaled >>> 8);
  assign x_ext  = x_q;
  // Feedback subtracts +FS when the bit was 1, adds FS when it was 0.
  assign acc_d  = acc_q + x_ext - (acc_q[22] ? -FS : FS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pi_q  <= '0;
      pq_q  <= '0;
      sum_q <= '0;
      x_q   <= '0;
      acc_q <= '0;
      rf_q  <= 1'b0;
    end else begin
      pi_q  <= bus.I_in * bus.cos_in;
      pq_q  <= bus.Q_in * bus.sin_in;
      sum_q <= pi_q - pq_q;
      x_q   <= x_d;
      if (state_q == S_IDLE) begin
        acc_q <= '0;
        rf_q  <= 1'b0;
      end else begin
        acc_q <= acc_d;
        rf_q  <= ~acc_q[22];
      end
    end
  end

  assign bus.RFOut     = rf_q;
  assign bus.tx_active = tx_active_q;
  assign bus.ramp_done = ramp_done_q;
endmodule

// File: tb/tb_tx_upconverter.sv
// Directed bench for tx_upconverter: reset, keying ramp timing, datapath vectors and DSM density.
module tb_tx_upconverter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  localparam longint FS = 524288;

  tx_upconverter_if bus();
  tx_upconverter #(.RAMP_DIV(4), .GAIN_BITS(9)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic signed [9:0] i, q, s, c;
    longint            x;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic signed [9:0] i, q, s, c);
    bus.I_in = i; bus.Q_in = q; bus.sin_in = s; bus.cos_in = c;
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    for (int k = 0; k < n; k++) begin
      tick(1);
      ones += int'(bus.RFOut);
    end
  endtask

  initial begin
    int     t, ones, peak;
    longint exp_ones;

    // x = I*cos - Q*sin at unity gain
    tbl[0] = '{i: 10'sd256,  q: 10'sd0,    s: 10'sd0,    c: 10'sd511,  x: 130816};
    tbl[1] = '{i: -10'sd512, q: 10'sd0,    s: 10'sd0,    c: 10'sd511,  x: -261632};
    tbl[2] = '{i: 10'sd0,    q: 10'sd100,  s: 10'sd200,  c: 10'sd0,    x: -20000};
    tbl[3] = '{i: -10'sd512, q: -10'sd512, s: 10'sd511,  c: -10'sd512, x: 523776};
    tbl[4] = '{i: -10'sd512, q: -10'sd512, s: -10'sd512, c: 10'sd511,  x: -523776};
    tbl[5] = '{i: 10'sd3,    q: -10'sd7,   s: 10'sd5,    c: -10'sd2,   x: 29};
    tbl[6] = '{i: 10'sd0,    q: 10'sd0,    s: 10'sd0,    c: 10'sd0,    x: 0};

    rst_n = 1'b1;
    bus.key = 1'b0;
    set_in(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rfout", bus.RFOut, 0);
    chk("rst_tx_active", bus.tx_active, 0);
    chk("rst_ramp_done", bus.ramp_done, 0);

    // key held high while reset is asserted must not start a ramp
    bus.key = 1'b1;
    tick(5);
    chk("rst_key_tx_active", bus.tx_active, 0);
    chk("rst_key_rfout", bus.RFOut, 0);
    chk("rst_key_gain", dut.gain_q, 0);
    @(negedge clk) rst_n = 1'b1;
    tick(1);
    chk("release_tx_active", bus.tx_active, 1);

    // zero input: DSM toggles starting with 1 on the first non-IDLE clock
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk("dsm_alternate", bus.RFOut, (k % 2 == 0) ? 1 : 0);
    end

    // t counts clocks since tx_active rose (= entry into RAMP_UP)
    t = 8;
    while (!bus.ramp_done && t < 2000) begin
      tick(1);
      t++;
      if (t == 400) chk("gain_at_400", dut.gain_q, 100);
      if (t == 403) chk("gain_at_403", dut.gain_q, 100);
      if (t == 404) chk("gain_at_404", dut.gain_q, 101);
    end
    chk_rng("ramp_up_clocks", t, 1023, 1025);
    chk("gain_full", dut.gain_q, 256);

    for (int v = 0; v < 7; v++) begin
      set_in(tbl[v].i, tbl[v].q, tbl[v].s, tbl[v].c);
      tick(4);
      chk($sformatf("vec%0d_x", v), dut.x_q, tbl[v].x);
      count_ones(512, ones);
      exp_ones = (512 * (FS + tbl[v].x) + FS) / (2 * FS);
      chk_rng($sformatf("vec%0d_ones", v), ones, exp_ones - 2, exp_ones + 2);
    end

    set_in(10'sd256, 0, 0, 10'sd511);
    tick(4);
    chk("density_x", dut.x_q, 130816);
    count_ones(4096, ones);
    chk_rng("density_4096", ones, 2558, 2560);
    chk("on_ramp_done", bus.ramp_done, 1);

    // asynchronous reset in the middle of a clock while ON
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rfout", bus.RFOut, 0);
    chk("async_tx_active", bus.tx_active, 0);
    chk("async_ramp_done", bus.ramp_done, 0);
    chk("async_acc", dut.acc_q, 0);
    bus.key = 1'b0;
    set_in(0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    tick(20);
    chk("idle_hold_tx_active", bus.tx_active, 0);
    chk("idle_hold_gain", dut.gain_q, 0);

    // short key: ramp up for 200 clocks then back down to IDLE
    bus.key = 1'b1;
    peak = 0;
    for (int k = 0; k < 200; k++) begin
      tick(1);
      if (int'(dut.gain_q) > peak) peak = int'(dut.gain_q);
    end
    bus.key = 1'b0;
    t = 0;
    while (bus.tx_active && t < 400) begin
      tick(1);
      t++;
      if (int'(dut.gain_q) > peak) peak = int'(dut.gain_q);
    end
    chk_rng("short_peak", peak, 49, 50);
    chk_rng("ramp_down_clocks", t, 196, 204);
    chk("down_gain", dut.gain_q, 0);
    chk("down_rfout", bus.RFOut, 0);
    chk("down_acc", dut.acc_q, 0);
    chk("down_ramp_done", bus.ramp_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
